// File: rtl/booth_pkg.sv
// Shared definitions for the radix-2 Booth multiplier controller: FSM states,
// default sizing and the Booth pair codes that select add or subtract.
package booth_pkg;

    localparam int N_DEFAULT     = 5;
    localparam int CNT_W_DEFAULT = 3;

    typedef enum logic [2:0] {
        IDLE,
        LD_M1,
        LD_M2,
        CHECK,
        SHIFT,
        OUT_HI,
        OUT_LO
    } state_t;

    localparam logic [1:0] PAIR_ADD = 2'b01;
    localparam logic [1:0] PAIR_SUB = 2'b10;

endpackage

// File: rtl/booth_iter_counter.sv
// Booth iteration counter: synchronous clear, increment, and a terminal-count
// flag raised while the count sits at N-1 (the final iteration).
module booth_iter_counter #(
    parameter int N     = 5,
    parameter int CNT_W = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic inc,
    output logic last
);

    logic [CNT_W-1:0] count;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values, independent of process ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (inc) begin
            count <= count + 1'b1;
        end
    end

    assign last = (count == CNT_W'(N - 1));

endmodule

// File: rtl/booth_controller.sv
// Control FSM for the 5-bit radix-2 Booth multiplier datapath. Defining
// BOOTH_CTRL_FAST_SHIFT_EN folds the shift into CHECK when the pair needs no add/sub.
module booth_controller
    import booth_pkg::*;
#(
    parameter int N     = N_DEFAULT,
    parameter int CNT_W = CNT_W_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic q1,
    input  logic q0,
    output logic ready,
    output logic ldM1,
    output logic ldM2,
    output logic clrq,
    output logic ldq,
    output logic sh,
    output logic add,
    output logic sub,
    output logic sel,
    output logic out_valid,
    output logic out_last
);

    state_t     state;
    state_t     state_next;
    logic       cnt_clear;
    logic       cnt_inc;
    logic       cnt_last;
    logic [1:0] pair;

    assign pair = {q1, q0};

    booth_iter_counter #(
        .N    (N),
        .CNT_W(CNT_W)
    ) u_iter_counter (
        .clk  (clk),
        .rst  (rst),
        .clear(cnt_clear),
        .inc  (cnt_inc),
        .last (cnt_last)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every output gets a default before the case so no path can
    // leave a signal unassigned and infer a latch.
    always_comb begin
        state_next = state;
        ready      = 1'b0;
        ldM1       = 1'b0;
        ldM2       = 1'b0;
        clrq       = 1'b0;
        ldq        = 1'b0;
        sh         = 1'b0;
        add        = 1'b0;
        sub        = 1'b0;
        sel        = 1'b0;
        out_valid  = 1'b0;
        out_last   = 1'b0;
        cnt_clear  = 1'b0;
        cnt_inc    = 1'b0;

        case (state)
            IDLE: begin
                ready = 1'b1;
                if (start) begin
                    state_next = LD_M1;
                end
            end
            LD_M1: begin
                ldM1       = 1'b1;
                clrq       = 1'b1;
                state_next = LD_M2;
            end
            LD_M2: begin
                ldM2       = 1'b1;
                cnt_clear  = 1'b1;
                state_next = CHECK;
            end
            CHECK: begin
                state_next = SHIFT;
                case (pair)
                    PAIR_ADD: begin
                        add = 1'b1;
                        ldq = 1'b1;
                    end
                    PAIR_SUB: begin
                        sub = 1'b1;
                        ldq = 1'b1;
                    end
                    default: begin
`ifdef BOOTH_CTRL_FAST_SHIFT_EN
                        // Nothing to accumulate: shift here and skip SHIFT.
                        sh         = 1'b1;
                        cnt_inc    = 1'b1;
                        state_next = cnt_last ? OUT_HI : CHECK;
`else
                        state_next = SHIFT;
`endif
                    end
                endcase
            end
            SHIFT: begin
                sh         = 1'b1;
                cnt_inc    = 1'b1;
                state_next = cnt_last ? OUT_HI : CHECK;
            end
            OUT_HI: begin
                out_valid  = 1'b1;
                state_next = OUT_LO;
            end
            OUT_LO: begin
                sel        = 1'b1;
                out_valid  = 1'b1;
                out_last   = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_booth_controller.sv
// Bench for booth_controller paired with a behavioural Booth datapath; products
// and latencies come from plain signed arithmetic, not from the FSM structure.
module tb_booth_controller;

    localparam int N = 5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic q1, q0;
    logic ready, ldM1, ldM2, clrq, ldq, sh, add, sub, sel, out_valid, out_last;

    int checks = 0;
    int errors = 0;

    logic [4:0] op_a = '0;
    logic [4:0] op_b = '0;
    logic [4:0] data_in;
    logic [4:0] data_out;

    // Datapath stand-in; the accumulator carries one guard bit so that a
    // -16 multiplicand cannot overflow during subtraction.
    logic [5:0] acc  = '0;
    logic [4:0] mq   = '0;
    logic       qm1  = 1'b0;
    logic [4:0] mreg = '0;

    always #5 clk = ~clk;

    booth_controller #(.N(N), .CNT_W(3)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .q1       (q1),
        .q0       (q0),
        .ready    (ready),
        .ldM1     (ldM1),
        .ldM2     (ldM2),
        .clrq     (clrq),
        .ldq      (ldq),
        .sh       (sh),
        .add      (add),
        .sub      (sub),
        .sel      (sel),
        .out_valid(out_valid),
        .out_last (out_last)
    );

    assign data_in  = ldM1 ? op_a : (ldM2 ? op_b : 5'b10110);
    assign q1       = mq[0];
    assign q0       = qm1;
    assign data_out = sel ? mq : acc[4:0];

    always @(posedge clk) begin
        if (ldM1) mreg <= data_in;
        if (clrq) begin
            acc <= '0;
            mq  <= '0;
            qm1 <= 1'b0;
        end else if (ldM2) begin
            acc <= '0;
            mq  <= data_in;
            qm1 <= 1'b0;
        end else if (ldq) begin
            acc <= add ? acc + {mreg[4], mreg} : acc - {mreg[4], mreg};
        end else if (sh) begin
            {acc, mq, qm1} <= {acc[5], acc, mq};
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            check("never_add_and_sub", 32'(add & sub), 32'd0);
            check("never_ldq_and_sh", 32'(ldq & sh), 32'd0);
            check("phase_onehot", 32'($countones({ready, ldM1, ldM2, out_valid}) <= 1), 32'd1);
        end
    end

    function automatic logic [9:0] ref_product(input logic [4:0] a, input logic [4:0] b);
        int pa, pb, p;
        pa = $signed(a);
        pb = $signed(b);
        p  = pa * pb;
        return p[9:0];
    endfunction

    // Cycle (counted from the start-sampling cycle) of the high output word.
    function automatic int ref_latency(input logic [4:0] b);
`ifdef BOOTH_CTRL_FAST_SHIFT_EN
        int   k;
        logic prev;
        k    = 0;
        prev = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (b[i] != prev) k++;
            prev = b[i];
        end
        return 3 + N + k;
`else
        return 3 + 2 * N;
`endif
    endfunction

    task automatic run_mult(input logic [4:0] a, input logic [4:0] b, input bit noisy, input string name);
        logic [9:0] prod;
        logic [4:0] hi, lo;
        int         lat;
        bit         ready_bad, valid_bad;
        prod      = ref_product(a, b);
        lat       = ref_latency(b);
        hi        = 5'h1f ^ prod[9:5];
        lo        = 5'h1f ^ prod[4:0];
        ready_bad = 1'b0;
        valid_bad = 1'b0;
        op_a      = a;
        op_b      = b;
        @(negedge clk);
        check({name, "_idle_ready"}, 32'(ready), 32'd1);
        start = 1'b1;
        for (int c = 1; c <= lat + 3; c++) begin
            @(negedge clk);
            start = noisy && (c <= 10) && (c <= lat + 1);
            if (ready !== ((c > lat + 1) ? 1'b1 : 1'b0)) ready_bad = 1'b1;
            if (out_valid) begin
                if (c == lat && !sel && !out_last) hi = data_out;
                else if (c == lat + 1 && sel && out_last) lo = data_out;
                else valid_bad = 1'b1;
            end else if (c == lat || c == lat + 1 || out_last) begin
                valid_bad = 1'b1;
            end
        end
        start = 1'b0;
        check({name, "_hi_word"}, 32'(hi), 32'(prod[9:5]));
        check({name, "_lo_word"}, 32'(lo), 32'(prod[4:0]));
        check({name, "_valid_timing"}, 32'(valid_bad), 32'd0);
        check({name, "_ready_timing"}, 32'(ready_bad), 32'd0);
    endtask

    typedef struct {
        logic [4:0] a;
        logic [4:0] b;
        logic [4:0] hi;
        logic [4:0] lo;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int seen;
        vecs[0] = '{a: 5'd3,     b: 5'b11110, hi: 5'b11111, lo: 5'b11010};
        vecs[1] = '{a: 5'd7,     b: 5'd7,     hi: 5'b00001, lo: 5'b10001};
        vecs[2] = '{a: 5'b10000, b: 5'b10000, hi: 5'b01000, lo: 5'b00000};
        vecs[3] = '{a: 5'b10000, b: 5'd15,    hi: 5'b11000, lo: 5'b10000};
        vecs[4] = '{a: 5'd0,     b: 5'b11011, hi: 5'b00000, lo: 5'b00000};
        vecs[5] = '{a: 5'd15,    b: 5'd15,    hi: 5'b00111, lo: 5'b00001};

        // Reset state while rst is held.
        @(negedge clk);
        check("rst_ready", 32'(ready), 32'd1);
        check("rst_strobes", 32'({ldM1, ldM2, clrq, ldq, sh, add, sub, sel, out_valid, out_last}), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Table vectors: the model must agree with the hand-derived words.
        for (int i = 0; i < 6; i++) begin
            check($sformatf("vec%0d_model_hi", i), 32'(ref_product(vecs[i].a, vecs[i].b) >> 5), 32'(vecs[i].hi));
            run_mult(vecs[i].a, vecs[i].b, 1'b0, $sformatf("vec%0d", i));
        end
`ifndef BOOTH_CTRL_FAST_SHIFT_EN
        check("fixed_latency_13", 32'(ref_latency(5'b11110)), 32'd13);
`endif

        // start pulses mid-run must be ignored.
        run_mult(5'd3, 5'b11110, 1'b1, "noisy_start");

        // Asynchronous reset on the second CHECK of a run.
        op_a = 5'd9;
        op_b = 5'b10101;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        seen  = 0;
        for (int c = 0; c < 20 && seen < 2; c++) begin
            if (ldq) seen++;
            if (seen < 2) @(negedge clk);
        end
        check("rst_reached_check", 32'(seen), 32'd2);
        rst = 1'b1;
        #1;
        check("midrun_rst_ready", 32'(ready), 32'd1);
        check("midrun_rst_strobes", 32'({ldM1, ldM2, clrq, ldq, sh, add, sub, sel, out_valid, out_last}), 32'd0);
        @(negedge clk);
        check("midrun_rst_no_valid", 32'(out_valid), 32'd0);
        rst = 1'b0;
        run_mult(5'd9, 5'b10101, 1'b0, "after_rst");

`ifdef BOOTH_CTRL_FAST_SHIFT_EN
        check("fast_zero_latency", 32'(ref_latency(5'd0)), 32'd8);
        run_mult(5'd5, 5'd0, 1'b0, "fast_5x0");
        run_mult(5'd5, 5'd10, 1'b0, "fast_5x10");
`endif

        // Randomized operands against the arithmetic reference.
        for (int i = 0; i < 24; i++) begin
            run_mult(5'($urandom), 5'($urandom), 1'($urandom_range(0, 1)), $sformatf("rand%0d", i));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
